// File: rtl/fifo_sync_flags_if.sv
// Handshake/status bundle for fifo_sync_flags.
// The master side (producer/consumer logic) drives the write/read requests and clr_err.
// The slave side (the FIFO) returns read data, the read strobe, the fill level and the flags.
interface fifo_sync_flags_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  localparam int LEVEL_W = $clog2(DEPTH + 1);

  logic               wr_en;
  logic [WIDTH-1:0]   data_in;
  logic               rd_en;
  logic               clr_err;
  logic [WIDTH-1:0]   data_out;
  logic               rd_valid;
  logic               empty;
  logic               full;
  logic               almost_empty;
  logic               almost_full;
  logic [LEVEL_W-1:0] level;
  logic               overflow;
  logic               underflow;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, rd_valid, empty, full, almost_empty, almost_full,
           level, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, rd_valid, empty, full, almost_empty, almost_full,
           level, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO of any depth >= 2 with registered read data,
// a read-valid strobe, fill level and programmable almost-full/almost-empty flags.
// Optional feature macro: FIFO_ERR_EN enables sticky overflow/underflow flags
// (cleared by reset or clr_err); without it both flags are constant 0.
// All status outputs come straight from registers; none depends combinationally on inputs.
module fifo_sync_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = 60,
  parameter int AE_LEVEL = 4
) (
  input logic               clk,
  input logic               reset,
  fifo_sync_flags_if.slave  bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = $clog2(DEPTH + 1);

  // Reject parameter sets that would make the flags or pointer wrap meaningless.
  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("fifo_sync_flags: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
      $error("fifo_sync_flags: DEPTH must be >= 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
      $error("fifo_sync_flags: AF_LEVEL must be in 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
      $error("fifo_sync_flags: AE_LEVEL must be in 0..DEPTH-1");
    end
  endgenerate

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic [LEVEL_W-1:0] count_next;
  logic [WIDTH-1:0]   rd_data;
  logic               rd_strobe;
  logic               is_empty;
  logic               is_full;
  logic               is_almost_empty;
  logic               is_almost_full;
  logic               do_write;
  logic               do_read;

  // Acceptance uses only the registered flags, so a full FIFO rejects writes and an
  // empty FIFO rejects reads even when both requests arrive together.
  always_comb begin
    do_write   = bus.wr_en & ~is_full;
    do_read    = bus.rd_en & ~is_empty;
    count_next = count;
    case ({do_write, do_read})
      2'b10:   count_next = count + LEVEL_W'(1);
      2'b01:   count_next = count - LEVEL_W'(1);
      default: count_next = count;
    endcase
  end

  // Storage array; intentionally not reset, stale words are unreachable after a pointer reset.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers, level, read data/strobe and flags; flags are registered from the next level
  // so they always agree with the level register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      rd_data         <= '0;
      rd_strobe       <= 1'b0;
      is_empty        <= 1'b1;
      is_full         <= 1'b0;
      is_almost_empty <= 1'b1;
      is_almost_full  <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_read) begin
        rd_ptr  <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_strobe       <= do_read;
      count           <= count_next;
      is_empty        <= (count_next == LEVEL_W'(0));
      is_full         <= (count_next == LEVEL_W'(DEPTH));
      is_almost_empty <= (count_next <= LEVEL_W'(AE_LEVEL));
      is_almost_full  <= (count_next >= LEVEL_W'(AF_LEVEL));
    end
  end

`ifdef FIFO_ERR_EN
  logic ovf_flag;
  logic unf_flag;

  // Sticky error flags: a new error event wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else begin
      if (bus.wr_en && is_full) begin
        ovf_flag <= 1'b1;
      end else if (bus.clr_err) begin
        ovf_flag <= 1'b0;
      end else begin
        ovf_flag <= ovf_flag;
      end
      if (bus.rd_en && is_empty) begin
        unf_flag <= 1'b1;
      end else if (bus.clr_err) begin
        unf_flag <= 1'b0;
      end else begin
        unf_flag <= unf_flag;
      end
    end
  end

  assign bus.overflow  = ovf_flag;
  assign bus.underflow = unf_flag;
`else
  // Error tracking compiled out: flags tied low and clr_err has no effect.
  logic unused_clr_err;
  assign unused_clr_err = bus.clr_err;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif

  assign bus.data_out     = rd_data;
  assign bus.rd_valid     = rd_strobe;
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_empty = is_almost_empty;
  assign bus.almost_full  = is_almost_full;
  assign bus.level        = count;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench for fifo_sync_flags (DEPTH=5, WIDTH=8, AF_LEVEL=4, AE_LEVEL=1).
// A queue model tracks stored words; accepted reads push the expected word onto a
// scoreboard that is popped whenever the DUT raises rd_valid.
module tb_fifo_sync_flags;
  localparam int W   = 8;
  localparam int D   = 5;
  localparam int AF  = 4;
  localparam int AE  = 1;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [W-1:0] m_mem [$];
  logic [W-1:0] sb    [$];
  logic [W-1:0] exp_dout;
  logic         exp_rv;
  logic         m_ovf;
  logic         m_unf;

  fifo_sync_flags_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fifo_sync_flags #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare every output #1 after the edge.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r,
                      input logic rst, input logic clr);
    logic full_b;
    logic empty_b;
    logic do_w;
    logic do_r;
    bus.wr_en   = w;
    bus.data_in = d;
    bus.rd_en   = r;
    bus.clr_err = clr;
    reset       = rst;
    full_b  = (m_mem.size() == D);
    empty_b = (m_mem.size() == 0);
    do_w    = w & ~full_b;
    do_r    = r & ~empty_b;
    @(posedge clk);
    #1;
    if (rst) begin
      m_mem.delete();
      sb.delete();
      exp_dout = '0;
      exp_rv   = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
    end else begin
      if (do_r) sb.push_back(m_mem.pop_front());
      if (do_w) m_mem.push_back(d);
      exp_rv = do_r;
`ifdef FIFO_ERR_EN
      if (w && full_b) m_ovf = 1'b1;
      else if (clr)    m_ovf = 1'b0;
      if (r && empty_b) m_unf = 1'b1;
      else if (clr)     m_unf = 1'b0;
`endif
    end
    chk("rd_valid", bus.rd_valid, exp_rv);
    if (bus.rd_valid === 1'b1 && sb.size() > 0) exp_dout = sb.pop_front();
    chk("data_out", bus.data_out, exp_dout);
    chk("level", bus.level, m_mem.size());
    chk("empty", bus.empty, m_mem.size() == 0);
    chk("full", bus.full, m_mem.size() == D);
    chk("almost_empty", bus.almost_empty, m_mem.size() <= AE);
    chk("almost_full", bus.almost_full, m_mem.size() >= AF);
    chk("overflow", bus.overflow, m_ovf);
    chk("underflow", bus.underflow, m_unf);
  endtask

  task automatic wr(input logic [W-1:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic rd();                      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); endtask
  task automatic idle();                    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); endtask
  task automatic both(input logic [W-1:0] d); step(1'b1, d, 1'b1, 1'b0, 1'b0); endtask
  task automatic clr();                     step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_dout = '0;
    exp_rv   = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    bus.wr_en = 1'b0; bus.data_in = '0; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    reset = 1'b1;

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // 1: fill to full, rejected extra write, drain in order
    for (int i = 1; i <= 5; i++) wr(W'(i));
    chk("t1_full", bus.full, 1'b1);
    chk("t1_level", bus.level, 3'd5);
    wr(8'hFF);
    for (int i = 0; i < 5; i++) rd();
    chk("t1_last", bus.data_out, 8'h05);
    idle();
    chk("t1_empty", bus.empty, 1'b1);
    clr();

    // 2: wrap across pointer end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) wr(W'(8'h10 + i + 4 * k));
      for (int i = 0; i < 4; i++) rd();
    end
    idle();

    // 3: simultaneous requests at level 2, empty and full
    wr(8'h21); wr(8'h22);
    both(8'h23);
    chk("t3_level2", bus.level, 3'd2);
    rd(); rd(); idle();
    both(8'h30);
    chk("t3_empty_both_lvl", bus.level, 3'd1);
    chk("t3_empty_both_rv", bus.rd_valid, 1'b0);
    for (int i = 1; i <= 4; i++) wr(W'(8'h30 + i));
    both(8'h3F);
    chk("t3_full_both_lvl", bus.level, 3'd4);
    chk("t3_full_both_data", bus.data_out, 8'h30);
    for (int i = 0; i < 4; i++) rd();
    idle();

    // 4: almost flags across a full fill and drain
    for (int i = 0; i < 5; i++) wr(W'(8'h40 + i));
    for (int i = 0; i < 5; i++) rd();
    idle();

    // 5: reset with a pending write discards contents
    wr(8'h51); wr(8'h52); wr(8'h53);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("t5_level", bus.level, 3'd0);
    chk("t5_dout", bus.data_out, 8'h00);
    wr(8'hA5); rd(); idle();
    chk("t5_new_data", bus.data_out, 8'hA5);

    // 6: error flags (sticky when FIFO_ERR_EN, constant 0 otherwise)
    for (int i = 0; i < 5; i++) wr(W'(8'h60 + i));
    wr(8'h6F);
    idle(); idle();
    clr();
    for (int i = 0; i < 5; i++) rd();
    rd();
    idle();
    both(8'h70);
    clr();
    rd(); idle();

    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
